pipelined_multiplier: RTL and testbench

//  Parametrised, elastic signed/unsigned integer multiplier for the MIPS CPU execute path (MULT/MULTU, HI/LO write).

---
 rtl/mul_pkg.sv | 17 +
 rtl/pipe_slice.sv | 50 +++++
 rtl/pipelined_multiplier.sv | 102 ++++++++++
 tb/tb_pipelined_multiplier.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared defaults and width helpers for the pipelined integer multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH_DEFAULT  = 32;
  localparam int unsigned MUL_STAGES_DEFAULT = 2;

  // Result is the full double-width product (HI:LO).
  function automatic int unsigned mul_res_width(input int unsigned width);
    return 2 * width;
  endfunction

  // One extra bit lets signed and unsigned operands share one signed multiplier.
  function automatic int unsigned mul_ext_width(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic register slice: valid bit plus payload, loads when empty or when
// the downstream slice takes its current content; flush drops the valid bit.
module pipe_slice #(
  parameter int unsigned DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;

  // Payload only moves with a real transfer so idle-cycle operands never land.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Elastic signed/unsigned multiplier (MULT/MULTU) with valid/ready and flush.
// Define MULTIPLIER_ACCUM_EN to add the MADD/MSUB accumulate ports.
module pipelined_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = MUL_WIDTH_DEFAULT,
  parameter int unsigned STAGES = MUL_STAGES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     input1,
  input  logic [WIDTH-1:0]     input2,
`ifdef MULTIPLIER_ACCUM_EN
  input  logic                 acc_en,
  input  logic                 acc_sub,
  input  logic [2*WIDTH-1:0]   acc_in,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned RW = mul_res_width(WIDTH);
  localparam int unsigned XW = mul_ext_width(WIDTH);
`ifdef MULTIPLIER_ACCUM_EN
  localparam int unsigned PW = 2 * RW + 2;
`else
  localparam int unsigned PW = RW;
`endif

  logic signed [XW-1:0] a_ext, b_ext;
  logic        [RW-1:0] product;
  logic        [PW-1:0] head_pay;
  logic        [PW-1:0] src [STAGES];
  logic        [RW-1:0] last_in, last_q;
  logic        [STAGES:0] vld, rdy;

  // Extension bit is the sign only in signed mode; the truncated product is exact.
  assign a_ext   = {is_signed & input1[WIDTH-1], input1};
  assign b_ext   = {is_signed & input2[WIDTH-1], input2};
  assign product = RW'(a_ext) * RW'(b_ext);

`ifdef MULTIPLIER_ACCUM_EN
  function automatic logic [RW-1:0] finish_op(input logic [PW-1:0] p);
    logic          en, sub;
    logic [RW-1:0] acc, prd;
    {en, sub, acc, prd} = p;
    if (!en) begin
      return prd;
    end
    return sub ? (acc - prd) : (acc + prd);
  endfunction

  assign head_pay = {acc_en, acc_sub, acc_in, product};
  assign last_in  = finish_op(src[STAGES-1]);
`else
  assign head_pay = product;
  assign last_in  = src[STAGES-1];
`endif

  assign src[0]      = head_pay;
  assign vld[0]      = in_valid;
  assign rdy[STAGES] = out_ready;

  // Slice chain: inner slices carry the raw payload, the last one holds the result.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k + 1 < STAGES) begin : g_mid
      pipe_slice #(.DW(PW)) u_slice (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .valid_i (vld[k]),
        .ready_o (rdy[k]),
        .data_i  (src[k]),
        .valid_o (vld[k+1]),
        .ready_i (rdy[k+1]),
        .data_o  (src[k+1])
      );
    end else begin : g_last
      pipe_slice #(.DW(RW)) u_slice (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .valid_i (vld[k]),
        .ready_o (rdy[k]),
        .data_i  (last_in),
        .valid_o (vld[k+1]),
        .ready_i (rdy[k+1]),
        .data_o  (last_q)
      );
    end
  end

  assign in_ready  = rdy[0] && !flush && !reset;
  assign out_valid = vld[STAGES];
  assign result    = last_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Bench for pipelined_multiplier: directed vectors on a 32x32/2-stage instance plus
// a shared random run over several WIDTH/STAGES instances against a queue model.
module tb_pipelined_multiplier;

  localparam int NI = 4;

  function automatic int cw(input int g);
    return (g == 3) ? 16 : 32;
  endfunction

  function automatic int cs(input int g);
    return (g == 1) ? 1 : (g == 2) ? 4 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, is_signed, out_ready;
  logic [31:0]   op1, op2;
  logic          acc_en, acc_sub;
  logic [63:0]   acc_in;
  logic [NI-1:0] rdy, ov;
  logic [63:0]   res [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = cw(g);
    localparam int S = cs(g);
    logic [2*W-1:0] r;
    pipelined_multiplier #(.WIDTH(W), .STAGES(S)) u_dut (
      .clock     (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .is_signed (is_signed),
      .input1    (op1[W-1:0]),
      .input2    (op2[W-1:0]),
`ifdef MULTIPLIER_ACCUM_EN
      .acc_en    (acc_en),
      .acc_sub   (acc_sub),
      .acc_in    (acc_in[2*W-1:0]),
`endif
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .result    (r)
    );
    assign res[g] = 64'(r);
  end

  int checks = 0;
  int errors = 0;

  logic [63:0] eq [NI][64];
  int          hd [NI];
  int          tl [NI];
  logic        pend [NI];
  logic [63:0] held [NI];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign/zero-extended operands.
  function automatic logic [63:0] model(input int w, input logic sg, input logic [31:0] a,
                                        input logic [31:0] b, input logic en, input logic sub,
                                        input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] p, r, m;
    if (w == 16) begin
      sa = sg ? longint'($signed(a[15:0])) : longint'(a[15:0]);
      sb = sg ? longint'($signed(b[15:0])) : longint'(b[15:0]);
      m  = 64'h0000_0000_FFFF_FFFF;
    end else begin
      sa = sg ? longint'($signed(a)) : longint'(a);
      sb = sg ? longint'($signed(b)) : longint'(b);
      m  = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    p = 64'(sa * sb);
    r = !en ? p : (sub ? acc - p : acc + p);
    return r & m;
  endfunction

  // Decides this cycle's transfers (they happen at the coming posedge).
  task automatic monitor();
    for (int i = 0; i < NI; i++) begin
      if (reset || flush) begin
        hd[i] = 0; tl[i] = 0; pend[i] = 1'b0;
      end else begin
        if (pend[i]) begin
          chk($sformatf("hold_valid[%0d]", i), 64'(ov[i]), 64'd1);
          chk($sformatf("hold_result[%0d]", i), res[i], held[i]);
        end
        pend[i] = 1'b0;
        if (ov[i]) begin
          if (out_ready) begin
            if (tl[i] == hd[i]) begin
              chk($sformatf("spurious_out[%0d]", i), 64'(ov[i]), 64'd0);
            end else begin
              chk($sformatf("result[%0d]#%0d", i, hd[i]), res[i], eq[i][hd[i] % 64]);
              hd[i]++;
            end
          end else begin
            pend[i] = 1'b1;
            held[i] = res[i];
          end
        end
        if (in_valid && rdy[i]) begin
          eq[i][tl[i] % 64] = model(cw(i), is_signed, op1, op2, acc_en, acc_sub, acc_in);
          tl[i]++;
        end
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    neg();
    pos();
  endtask

  task automatic run_one(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int lat;
    is_signed = sg; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b1;
    neg();
    chk({nm, "_ready"}, 64'(rdy[0]), 64'd1);
    pos();
    in_valid = 1'b0;
    lat = 1;
    neg();
    while (!ov[0] && lat < 20) begin
      pos();
      lat++;
      neg();
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk({nm, "_result"}, res[0], exp);
    pos();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tv [8];
  int   nz, nout, first, last, nacc;

  initial begin
    tv[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tv[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    tv[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    tv[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    tv[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    tv[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    tv[6] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    tv[7] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    for (int i = 0; i < NI; i++) begin
      hd[i] = 0; tl[i] = 0; pend[i] = 1'b0; held[i] = '0;
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; acc_en = 1'b0; acc_sub = 1'b0; acc_in = '0;

    // Reset held for 10 cycles
    for (int c = 0; c < 10; c++) begin
      pos();
      neg();
      chk("reset_out_valid", 64'(ov), 64'd0);
      chk("reset_result", res[0], 64'd0);
    end
    pos();
    reset = 1'b0;
    neg();
    chk("ready_after_reset", 64'(rdy), 64'hF);
    pos();

    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), tv[i].sg, tv[i].a, tv[i].b, tv[i].exp);
    end

    // Back-to-back issue with a free-running consumer
    nz = 0; nout = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8); is_signed = 1'($urandom_range(0, 1)); op1 = pick(); op2 = pick();
      neg();
      if (c < 8 && !rdy[0]) nz++;
      if (ov[0]) begin
        nout++;
        if (first < 0) first = c;
        last = c;
      end
      pos();
    end
    chk("b2b_stalls", 64'(nz), 64'd0);
    chk("b2b_count", 64'(nout), 64'd8);
    chk("b2b_consecutive", 64'(last - first), 64'd7);

    // Backpressure: consumer stalled while producer keeps offering
    out_ready = 1'b0; nacc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; is_signed = 1'($urandom_range(0, 1)); op1 = pick(); op2 = pick();
      neg();
      if (rdy[0]) nacc++;
      pos();
    end
    in_valid = 1'b0;
    neg();
    chk("stall_accepts", 64'(nacc), 64'd2);
    chk("stall_in_ready", 64'(rdy[0]), 64'd0);
    chk("stall_out_valid", 64'(ov[0]), 64'd1);
    pos();
    out_ready = 1'b1; nout = 0;
    for (int c = 0; c < 10; c++) begin
      neg();
      if (ov[0]) nout++;
      pos();
    end
    chk("drain_count", 64'(nout), 64'd2);

    // Flush with two ops in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; is_signed = 1'b0; op1 = 32'd100 + 32'(c); op2 = 32'd3;
      cyc();
    end
    flush = 1'b1; in_valid = 1'b1; op1 = 32'd9; op2 = 32'd9;
    neg();
    chk("flush_in_ready", 64'(rdy), 64'd0);
    pos();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; nout = 0;
    for (int c = 0; c < 6; c++) begin
      neg();
      if (|ov) nout++;
      pos();
    end
    chk("flush_no_output", 64'(nout), 64'd0);
    run_one("after_flush", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);

`ifdef MULTIPLIER_ACCUM_EN
    acc_en = 1'b1; acc_in = 64'h10; acc_sub = 1'b1;
    run_one("msub", 1'b0, 32'd3, 32'd4, 64'h4);
    acc_sub = 1'b0;
    run_one("madd", 1'b0, 32'd3, 32'd4, 64'h1C);
    acc_sub = 1'b1;
    run_one("msub_signed", 1'b1, 32'hFFFF_FFFF, 32'd5, 64'h15);
    acc_en = 1'b0;
`endif

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      is_signed = 1'($urandom_range(0, 1));
      if (in_valid) begin
        op1 = pick(); op2 = pick();
      end else begin
        op1 = 'x; op2 = 'x;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 299) == 0);
`ifdef MULTIPLIER_ACCUM_EN
      acc_en  = 1'($urandom_range(0, 1));
      acc_sub = 1'($urandom_range(0, 1));
      acc_in  = {$urandom, $urandom};
`endif
      cyc();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cyc();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("final_pending[%0d]", i), 64'(tl[i] - hd[i]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
